// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential divider and the control unit that drives it.
package seq_divider_pkg;

    localparam int DIV_WIDTH = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } div_state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell, shared with the ALU add path.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_subtractor.sv
// N-bit ripple subtractor a - b built from full-adder cells: b inverted, carry-in 1.
module ripple_subtractor #(
    parameter int N = 25
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         no_borrow
);

    logic [N:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (~b[i]),
            .cin (carry[i]),
            .s   (diff[i]),
            .cout(carry[i+1])
        );
    end

    // Carry-out of the chain is the inverse of the borrow.
    assign no_borrow = carry[N];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, START/BUSY/DONE handshake.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             unused_diff_msb;

    assign trial = {rem_q, quo_q[WIDTH-1]};

    ripple_subtractor #(.N(WIDTH + 1)) u_sub (
        .a        (trial),
        .b        ({1'b0, dvsr_q}),
        .diff     (diff),
        .no_borrow(no_borrow)
    );

    // With no borrow the difference is below the divisor, so its top bit is always 0.
    assign unused_diff_msb = diff[WIDTH];
    assign rem_next = no_borrow ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_next = {quo_q[WIDTH-2:0], no_borrow};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        div_zero_d  = div_zero_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvsr_d     = divisor;
                    quo_d      = dividend;
                    rem_d      = '0;
                    zero_d     = (divisor == '0);
                    cnt_d      = (divisor == '0) ? '0 : CNT_W'(WIDTH - 1);
                    div_zero_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                // A zero divisor spends one RUN cycle publishing the saturated result.
                if (zero_q) begin
                    quotient_d  = '1;
                    remainder_d = quo_q;
                    div_zero_d  = 1'b1;
                    done_d      = 1'b1;
                    state_d     = ST_FINISH;
                end else begin
                    rem_d = rem_next;
                    quo_d = quo_next;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        quotient_d  = quo_next;
                        remainder_d = rem_next;
                        done_d      = 1'b1;
                        state_d     = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results queued at START, checked on each DONE.
module tb_seq_divider;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient, remainder;
    logic         busy, done, div_zero;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   done_cnt = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .remainder(remainder),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.dvd = a;
        e.dvs = b;
        if (b == 0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Results are checked on the falling edge while DONE is high.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_cnt++;
            chk("sb_has_entry", 48'(sb.size() != 0), 48'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("quotient", 48'(quotient), 48'(e.q));
                chk("remainder", 48'(remainder), 48'(e.r));
                chk("div_zero", 48'(div_zero), 48'(e.dz));
                chk("busy_at_done", 48'(busy), 48'd1);
                if (e.dvs != 0) begin
                    chk("invariant", 48'(quotient) * 48'(e.dvs) + 48'(remainder), 48'(e.dvd));
                    chk("rem_lt_dvs", 48'(remainder < e.dvs), 48'd1);
                end
            end
        end
    end

    // Wait for DONE from a given edge count; returns the edge after which DONE was seen.
    task automatic wait_done(input int from_edge, output int at_edge);
        at_edge = from_edge;
        while (!done && at_edge < from_edge + 200) begin
            @(negedge clk);
            at_edge++;
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_lat, input string tag);
        int e;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
        wait_done(1, e);
        if (exp_lat > 0) chk(tag, 48'(e), 48'(exp_lat));
        else chk(tag, 48'(done), 48'd1);
    endtask

    initial begin
        int e;
        int dc0;
        logic [W-1:0] a, b;

        repeat (2) @(negedge clk);
        chk("rst_quotient", 48'(quotient), 48'd0);
        chk("rst_remainder", 48'(remainder), 48'd0);
        chk("rst_busy", 48'(busy), 48'd0);
        chk("rst_done", 48'(done), 48'd0);
        chk("rst_div_zero", 48'(div_zero), 48'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_op(24'd100, 24'd7, 25, "lat_100_7");
        do_op(24'hFFFFFF, 24'd1, 25, "lat_max_1");
        do_op(24'hFFFFFF, 24'hFFFFFF, 25, "lat_max_max");
        do_op(24'd3, 24'd10, 25, "lat_3_10");
        do_op(24'd5, 24'd0, 2, "lat_div0");
        @(negedge clk);
        chk("idle_busy", 48'(busy), 48'd0);
        chk("hold_div_zero", 48'(div_zero), 48'd1);
        chk("hold_quotient", 48'(quotient), 48'hFFFFFF);

        // START while busy and operand changes mid-run are ignored.
        dc0 = done_cnt;
        dividend = 24'd100;
        divisor  = 24'd7;
        start    = 1'b1;
        sb.push_back(model(24'd100, 24'd7));
        @(negedge clk);
        start = 1'b0;
        chk("busy_run", 48'(busy), 48'd1);
        repeat (9) @(negedge clk);
        dividend = 24'd9;
        divisor  = 24'd3;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 24'd55;
        divisor  = 24'd4;
        wait_done(11, e);
        chk("lat_ignore", 48'(e), 48'd25);
        repeat (30) @(negedge clk);
        chk("one_done", 48'(done_cnt - dc0), 48'd1);

        // START held high: next operation is accepted one cycle after FINISH.
        dividend = 24'd20;
        divisor  = 24'd3;
        start    = 1'b1;
        sb.push_back(model(24'd20, 24'd3));
        sb.push_back(model(24'd20, 24'd3));
        @(negedge clk);
        wait_done(1, e);
        chk("held_lat1", 48'(e), 48'd25);
        @(negedge clk);
        chk("held_gap_busy", 48'(busy), 48'd0);
        @(negedge clk);
        chk("held_reaccept", 48'(busy), 48'd1);
        start = 1'b0;
        wait_done(27, e);
        chk("held_lat2", 48'(e), 48'd51);
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of a division.
        dividend = 24'd100;
        divisor  = 24'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_quotient", 48'(quotient), 48'd0);
        chk("arst_remainder", 48'(remainder), 48'd0);
        chk("arst_busy", 48'(busy), 48'd0);
        chk("arst_done", 48'(done), 48'd0);
        chk("arst_div_zero", 48'(div_zero), 48'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("arst_idle", 48'(busy), 48'd0);
        do_op(24'd9, 24'd2, 25, "lat_9_2");

        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            b = W'($urandom) >> $urandom_range(0, W - 1);
            if (b == 0) b = 1;
            do_op(a, b, 0, "rand_done");
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 48'(sb.size()), 48'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
